// File: rtl/mem_port_arbiter.sv
// N-to-1 memory port arbiter: round-robin or fixed-priority grant, one transaction in flight.
// Latency: request sampled at edge t drives the downstream strobe in cycle t+1; port_resp is combinational on mem_resp.
// Backpressure: requesters hold read/write until their port_resp; the memory stalls by withholding mem_resp.
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1,
  parameter int IDW        = $clog2(NUM_PORTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               port_read,
  input  logic [NUM_PORTS-1:0]               port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    port_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    port_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] port_byte_enable,
  output logic [NUM_PORTS-1:0]               port_resp,
  output logic [DATA_WIDTH-1:0]              port_rdata,
  output logic                               mem_read,
  output logic                               mem_write,
  output logic [ADDR_WIDTH-1:0]              mem_address,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic [DATA_WIDTH/8-1:0]            mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  input  logic                               mem_resp,
  output logic [IDW-1:0]                     grant_id,
  output logic                               busy,
  output logic                               proto_err
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]            state;
  logic [NUM_PORTS-1:0]  req;
  logic                  any_req;
  logic [IDW-1:0]        win_idx;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        next_ptr;
  logic                  op_write_q;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [BE_WIDTH-1:0]   win_be;
  logic                  win_rd;
  logic                  win_wr;

  assign req     = port_read | port_write;
  assign any_req = |req;

  // Scan ports starting at ptr (round-robin) or at 0 (fixed priority); first requester wins.
  function automatic logic [IDW-1:0] pick_winner(input logic [NUM_PORTS-1:0] r,
                                                 input logic [IDW-1:0]       ptr);
    logic [IDW-1:0] w;
    logic [IDW-1:0] cand;
    logic           found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (RR_MODE != 0) ? IDW'((int'(ptr) + k) % NUM_PORTS) : IDW'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        w     = cand;
      end
    end
    return w;
  endfunction

  assign win_idx  = pick_winner(req, rr_ptr);
  assign next_ptr = (grant_id == IDW'(NUM_PORTS - 1)) ? '0 : grant_id + IDW'(1);

  // Mux the winning port's request fields out of the flattened buses.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_be    = '0;
    win_rd    = 1'b0;
    win_wr    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_idx == IDW'(i)) begin
        win_addr  = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        win_be    = port_byte_enable[i*BE_WIDTH +: BE_WIDTH];
        win_rd    = port_read[i];
        win_wr    = port_write[i];
      end
    end
  end

  // Arbitration FSM: latch the winner in IDLE, hold it in BUSY until mem_resp, then one dead IDLE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      grant_id        <= '0;
      rr_ptr          <= '0;
      op_write_q      <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      proto_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state           <= ST_BUSY;
            grant_id        <= win_idx;
            op_write_q      <= win_wr;
            mem_address     <= win_addr;
            mem_wdata       <= win_wdata;
            mem_byte_enable <= win_be;
            // Read+write together is illegal; it is issued as a write and flagged.
            if (win_rd && win_wr) begin
              proto_err <= 1'b1;
            end
          end
        end
        default: begin
          if (mem_resp) begin
            state <= ST_IDLE;
            if (RR_MODE != 0) begin
              rr_ptr <= next_ptr;
            end
          end
        end
      endcase
    end
  end

  // Completion pulse goes only to the granted port, and only while BUSY.
  always_comb begin
    port_resp = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_resp[i] = (state == ST_BUSY) && mem_resp && (grant_id == IDW'(i));
    end
  end

  assign busy       = (state == ST_BUSY);
  assign mem_read   = busy && !op_write_q;
  assign mem_write  = busy && op_write_q;
  assign port_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one round-robin and one fixed-priority instance share stimulus.
// Inputs change on the falling edge; outputs are sampled on the falling edge or shortly after.
// Memory responses are driven by hand inside each scenario task.
module tb_mem_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NP-1:0]    port_read;
  logic [NP-1:0]    port_write;
  logic [NP*AW-1:0] port_address;
  logic [NP*DW-1:0] port_wdata;
  logic [NP*BW-1:0] port_byte_enable;
  logic [DW-1:0]    mem_rdata;
  logic             mem_resp;

  logic [NP-1:0] a_port_resp, b_port_resp;
  logic [DW-1:0] a_port_rdata, b_port_rdata;
  logic          a_mem_read, b_mem_read, a_mem_write, b_mem_write;
  logic [AW-1:0] a_mem_address, b_mem_address;
  logic [DW-1:0] a_mem_wdata, b_mem_wdata;
  logic [BW-1:0] a_mem_be, b_mem_be;
  logic [IW-1:0] a_grant_id, b_grant_id;
  logic          a_busy, b_busy, a_proto_err, b_proto_err;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst),
    .port_read(port_read), .port_write(port_write), .port_address(port_address),
    .port_wdata(port_wdata), .port_byte_enable(port_byte_enable),
    .port_resp(a_port_resp), .port_rdata(a_port_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_address(a_mem_address),
    .mem_wdata(a_mem_wdata), .mem_byte_enable(a_mem_be),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .grant_id(a_grant_id), .busy(a_busy), .proto_err(a_proto_err)
  );

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst),
    .port_read(port_read), .port_write(port_write), .port_address(port_address),
    .port_wdata(port_wdata), .port_byte_enable(port_byte_enable),
    .port_resp(b_port_resp), .port_rdata(b_port_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address),
    .mem_wdata(b_mem_wdata), .mem_byte_enable(b_mem_be),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .grant_id(b_grant_id), .busy(b_busy), .proto_err(b_proto_err)
  );

  task automatic test_reset();
    rst = 1'b1;
    port_read = '0; port_write = '0; port_address = '0; port_wdata = '0;
    port_byte_enable = '0; mem_rdata = '0; mem_resp = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++; if ({a_mem_read, a_mem_write, a_busy, a_proto_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {a_mem_read, a_mem_write, a_busy, a_proto_err}); end
    checks++; if (a_port_resp !== 4'b0000) begin
      errors++; $display("FAIL reset_port_resp: got %b want 0000", a_port_resp); end
    checks++; if ({a_mem_address, a_mem_wdata, a_mem_be, a_grant_id} !== '0) begin
      errors++; $display("FAIL reset_regs: addr=%h wdata=%h be=%b gid=%0d want all 0", a_mem_address, a_mem_wdata, a_mem_be, a_grant_id); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({a_busy, a_mem_read, b_busy} !== 3'b000) begin
      errors++; $display("FAIL idle_no_req: got %b want 000", {a_busy, a_mem_read, b_busy}); end
  endtask

  task automatic test_single_read();
    port_read[1] = 1'b1;
    port_address[1*AW +: AW] = 32'h0000_0040;
    @(negedge clk);
    checks++; if ({a_busy, a_mem_read, a_mem_write} !== 3'b110) begin
      errors++; $display("FAIL read_strobe_t1: got %b want 110", {a_busy, a_mem_read, a_mem_write}); end
    checks++; if (a_mem_address !== 32'h40) begin
      errors++; $display("FAIL read_addr: got %h want 00000040", a_mem_address); end
    checks++; if (a_grant_id !== 2'd1) begin
      errors++; $display("FAIL read_grant: got %0d want 1", a_grant_id); end
    repeat (2) begin
      @(negedge clk);
      checks++; if ({a_mem_read, a_port_resp} !== 5'b1_0000) begin
        errors++; $display("FAIL read_wait: rd=%b resp=%b want 1/0000", a_mem_read, a_port_resp); end
    end
    mem_resp = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (a_port_resp !== 4'b0010) begin
      errors++; $display("FAIL read_resp: got %b want 0010", a_port_resp); end
    checks++; if (a_port_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_rdata: got %h want deadbeef", a_port_rdata); end
    @(posedge clk);
    #1 port_read = '0; mem_resp = 1'b0;
    @(negedge clk);
    checks++; if ({a_busy, a_mem_read, a_port_resp} !== 6'b00_0000) begin
      errors++; $display("FAIL read_done: busy=%b rd=%b resp=%b want 0/0/0000", a_busy, a_mem_read, a_port_resp); end
    checks++; if (a_grant_id !== 2'd1) begin
      errors++; $display("FAIL grant_hold_idle: got %0d want 1", a_grant_id); end
  endtask

  task automatic test_round_robin();
    int exp_a;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < NP; i++) port_address[i*AW +: AW] = 32'h1000 + 32'(i * 16);
    port_read = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_a = k % NP;
      @(negedge clk);
      checks++; if (a_busy !== 1'b1 || a_grant_id !== IW'(exp_a)) begin
        errors++; $display("FAIL rr_grant[%0d]: busy=%b gid=%0d want busy=1 gid=%0d", k, a_busy, a_grant_id, exp_a); end
      checks++; if (b_grant_id !== 2'd0) begin
        errors++; $display("FAIL fp_all_grant[%0d]: got %0d want 0", k, b_grant_id); end
      mem_resp = 1'b1;
      #1;
      checks++; if (a_port_resp !== 4'(1 << exp_a)) begin
        errors++; $display("FAIL rr_resp[%0d]: got %b want %b", k, a_port_resp, 4'(1 << exp_a)); end
      @(negedge clk);
      mem_resp = 1'b0;
      checks++; if ({a_busy, a_mem_read, a_port_resp} !== 6'b0) begin
        errors++; $display("FAIL rr_dead[%0d]: busy=%b rd=%b resp=%b want 0/0/0000", k, a_busy, a_mem_read, a_port_resp); end
    end
    port_read = '0;
  endtask

  task automatic test_fixed_priority();
    int exp_a;
    port_read = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      exp_a = (k % 2 == 0) ? 2 : 0;
      @(negedge clk);
      checks++; if (b_busy !== 1'b1 || b_grant_id !== 2'd0) begin
        errors++; $display("FAIL fp_grant[%0d]: busy=%b gid=%0d want busy=1 gid=0", k, b_busy, b_grant_id); end
      checks++; if (a_grant_id !== IW'(exp_a)) begin
        errors++; $display("FAIL rr_pair[%0d]: got %0d want %0d", k, a_grant_id, exp_a); end
      mem_resp = 1'b1;
      #1;
      checks++; if (b_port_resp !== 4'b0001) begin
        errors++; $display("FAIL fp_resp[%0d]: got %b want 0001", k, b_port_resp); end
      @(negedge clk);
      mem_resp = 1'b0;
    end
    port_read = '0;
  endtask

  task automatic test_write_be();
    port_write[0] = 1'b1;
    port_address[0 +: AW] = 32'h0000_0100;
    port_wdata[0 +: DW] = 32'h1234_5678;
    port_byte_enable[0 +: BW] = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({a_mem_write, a_mem_read} !== 2'b10 || a_mem_address !== 32'h100 ||
                    a_mem_wdata !== 32'h1234_5678 || a_mem_be !== 4'b0011) begin
        errors++; $display("FAIL write_hold[%0d]: wr=%b rd=%b addr=%h wdata=%h be=%b want 1/0/100/12345678/0011",
                           c, a_mem_write, a_mem_read, a_mem_address, a_mem_wdata, a_mem_be); end
    end
    mem_resp = 1'b1;
    #1;
    checks++; if (a_port_resp !== 4'b0001) begin
      errors++; $display("FAIL write_resp: got %b want 0001", a_port_resp); end
    @(negedge clk);
    mem_resp = 1'b0;
    port_write = '0;
    checks++; if ({a_mem_write, a_port_resp} !== 5'b0) begin
      errors++; $display("FAIL write_done: wr=%b resp=%b want 0/0000", a_mem_write, a_port_resp); end
  endtask

  task automatic test_proto_err();
    port_read[1] = 1'b1;
    port_write[1] = 1'b1;
    port_address[1*AW +: AW] = 32'h0000_0200;
    @(negedge clk);
    checks++; if ({a_mem_write, a_mem_read, a_grant_id} !== 4'b10_01) begin
      errors++; $display("FAIL proto_op: wr=%b rd=%b gid=%0d want 1/0/1", a_mem_write, a_mem_read, a_grant_id); end
    checks++; if (a_proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_set: got %b want 1", a_proto_err); end
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    port_read = '0;
    port_write = '0;
    repeat (3) @(negedge clk);
    checks++; if (a_proto_err !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL proto_sticky: err=%b busy=%b want 1/0", a_proto_err, a_busy); end
  endtask

  task automatic test_drop_request();
    port_read[3] = 1'b1;
    port_address[3*AW +: AW] = 32'h0000_0380;
    @(negedge clk);
    checks++; if (a_busy !== 1'b1 || a_grant_id !== 2'd3) begin
      errors++; $display("FAIL drop_grant: busy=%b gid=%0d want 1/3", a_busy, a_grant_id); end
    port_read = '0;
    @(negedge clk);
    checks++; if (a_mem_read !== 1'b1 || a_mem_address !== 32'h380) begin
      errors++; $display("FAIL drop_continue: rd=%b addr=%h want 1/00000380", a_mem_read, a_mem_address); end
    mem_resp = 1'b1;
    #1;
    checks++; if (a_port_resp !== 4'b1000) begin
      errors++; $display("FAIL drop_resp: got %b want 1000", a_port_resp); end
    @(negedge clk);
    mem_resp = 1'b0;
  endtask

  task automatic test_reset_mid();
    port_read[2] = 1'b1;
    port_address[2*AW +: AW] = 32'h0000_0300;
    @(negedge clk);
    checks++; if (a_busy !== 1'b1 || a_mem_read !== 1'b1) begin
      errors++; $display("FAIL mid_busy: busy=%b rd=%b want 1/1", a_busy, a_mem_read); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({a_busy, a_mem_read, a_mem_write, a_proto_err, a_port_resp} !== 8'b0) begin
      errors++; $display("FAIL mid_async_flags: busy=%b rd=%b wr=%b err=%b resp=%b want all 0",
                         a_busy, a_mem_read, a_mem_write, a_proto_err, a_port_resp); end
    checks++; if ({a_mem_address, a_grant_id} !== '0) begin
      errors++; $display("FAIL mid_async_regs: addr=%h gid=%0d want 0/0", a_mem_address, a_grant_id); end
    port_read = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_resp = 1'b1;
    #1;
    checks++; if (a_port_resp !== 4'b0000 || b_port_resp !== 4'b0000 || a_busy !== 1'b0) begin
      errors++; $display("FAIL late_resp: a=%b b=%b busy=%b want 0000/0000/0", a_port_resp, b_port_resp, a_busy); end
    @(negedge clk);
    mem_resp = 1'b0;
    checks++; if ({a_busy, a_mem_read} !== 2'b00) begin
      errors++; $display("FAIL late_resp_idle: busy=%b rd=%b want 0/0", a_busy, a_mem_read); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write_be();
    test_proto_err();
    test_drop_request();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- NUM_PORTS, 2, requester count; legal range 2..8.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8; BE_WIDTH = DATA_WIDTH/8.
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority with port 0 highest.
- IDW, $clog2(NUM_PORTS), grant index width.
REQ-002 Ports SHALL be as follows, one per line: name direction width meaning.
- clk input 1: single clock; all state updates on the rising edge.
- rst input 1: asynchronous, active-low reset.
- port_read input NUM_PORTS: per-port read request.
- port_write input NUM_PORTS: per-port write request.
- port_address input NUM_PORTS*ADDR_WIDTH: per-port address; port i occupies slice i.
- port_wdata input NUM_PORTS*DATA_WIDTH: per-port write data.
- port_byte_enable input NUM_PORTS*BE_WIDTH: per-port byte enables.
- port_resp output NUM_PORTS: per-port completion pulse.
- port_rdata output DATA_WIDTH: read data, broadcast to all ports.
- mem_read output 1: downstream read strobe.
- mem_write output 1: downstream write strobe.
- mem_address output ADDR_WIDTH: downstream address.
- mem_wdata output DATA_WIDTH: downstream write data.
- mem_byte_enable output BE_WIDTH: downstream byte enables.
- mem_rdata input DATA_WIDTH: downstream read data.
- mem_resp input 1: downstream completion.
- grant_id output IDW: index of the port currently granted.
- busy output 1: high while in BUSY.
- proto_err output 1: sticky protocol-error flag.

Function
REQ-003 The block SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-004 Request rule: a port is requesting when port_read[i] | port_write[i]; requesters hold the request until they see port_resp[i].
REQ-005 In IDLE with at least one request, the block SHALL, at the clock edge:
- select a winner;
- register the winner's address, wdata, byte enables, operation and index;
- enter BUSY.
REQ-006 With no request in IDLE, the FSM SHALL remain in IDLE and all downstream strobes SHALL stay 0.
REQ-007 Winner selection with RR_MODE=1: the lowest-indexed requester at or above rr_ptr, wrapping modulo NUM_PORTS.
REQ-008 Winner selection with RR_MODE=0: the lowest-indexed requester.
REQ-009 In BUSY, mem_read or mem_write SHALL be driven from the registered operation, and mem_address, mem_wdata and mem_byte_enable from the registered values. These outputs SHALL stay stable until mem_resp.
REQ-010 Latency: a request sampled at edge t SHALL produce a downstream strobe during cycle t+1. The minimum turnaround from request to port_resp is 2 cycles.
REQ-011 In a BUSY cycle with mem_resp=1:
- port_resp[grant_id] SHALL be 1 combinationally in that same cycle;
- port_rdata SHALL equal mem_rdata;
- the FSM SHALL return to IDLE at the next edge.
REQ-012 The cycle following a completion SHALL be IDLE with strobes at 0 (one mandatory dead cycle), so that a requester's just-completed request cannot be re-granted.
REQ-013 On each completion with RR_MODE=1, rr_ptr SHALL update to (grant_id+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
REQ-014 port_resp SHALL be all-zero outside BUSY. A mem_resp arriving in IDLE SHALL be ignored.
REQ-015 port_rdata SHALL pass mem_rdata through in every cycle; it is valid only alongside a port_resp pulse.
REQ-016 If the winning port asserts both read and write, the transaction SHALL be issued as a write and proto_err SHALL set.
REQ-017 proto_err SHALL stay set until reset.
REQ-018 If a granted port drops its request while BUSY, the downstream transaction SHALL still complete and port_resp SHALL still pulse.
REQ-019 Requests arriving while BUSY SHALL NOT affect the in-flight transaction; they are considered at the next IDLE cycle.
REQ-020 grant_id SHALL hold the last granted index while IDLE.

Reset
REQ-021 While rst=0, the block SHALL immediately force:
- FSM to IDLE;
- mem_read=0 and mem_write=0;
- mem_address, mem_wdata and mem_byte_enable to 0;
- port_resp=0;
- grant_id=0, rr_ptr=0, busy=0, proto_err=0.
REQ-022 A reset asserted mid-transaction SHALL drop the pending transaction. After reset deasserts, no port_resp SHALL be issued for the dropped transaction.
REQ-023 The first arbitration after reset SHALL treat port 0 as highest priority.

Verification
REQ-024 Single read: port 1 reads 0x0000_0040 and memory responds after 3 cycles with 0xDEAD_BEEF. Required:
- mem_read rises at t+1 with mem_address=0x40;
- port_resp[1] pulses once with port_rdata=0xDEAD_BEEF;
- port_resp[0] stays 0.
REQ-025 Round robin: NUM_PORTS=4, RR_MODE=1, all ports requesting continuously. Grant order SHALL be 0,1,2,3,0, with one dead IDLE cycle between grants.
REQ-026 Fixed priority: RR_MODE=0, ports 0 and 2 both requesting continuously. Port 0 SHALL win every arbitration.
REQ-027 Write with byte enables: port 0 writes 0x1234_5678, be=4'b0011, to 0x100. Required:
- mem_write=1 and mem_wdata, mem_byte_enable, mem_address hold 0x1234_5678, 4'b0011, 0x100 until mem_resp;
- port_resp[0] pulses once.
REQ-028 Reset mid-transaction: assert rst=0 two cycles into a BUSY read. Required:
- all outputs go to 0 asynchronously;
- a late mem_resp after reset produces no port_resp.
REQ-029 Protocol error: port 1 asserts read and write together. Required:
- a write is issued downstream;
- proto_err=1 and stays 1 after completion.
